// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller.
// State encoding is fixed so waveform decoders and debug tooling can rely on it.
package hazard_ctrl_pkg;

  localparam int REG_IDX_W = 3;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    STALL  = 3'd1,
    FLUSH  = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } ctrlState_t;

endpackage

// File: rtl/hazard_ctrl_reg_scoreboard.sv
// Per-register pending-write countdown: loaded at issue, counts down to the write.
// A count of 1 means the write lands this cycle and is covered by the bypass file.
module reg_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int WB_LAT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [REG_IDX_W-1:0] loadSel,
  input  logic [REG_IDX_W-1:0] rdSelA,
  input  logic [REG_IDX_W-1:0] rdSelB,
  output logic [1:0]           rdCntA,
  output logic [1:0]           rdCntB,
  output logic [NUM_REGS-1:0]  busyMask,
  output logic                 allIdle
);

  logic [NUM_REGS-1:0][1:0] cntAll;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gCnt
      logic [1:0] cntReg;

      // A fresh load wins over the countdown of the same register.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cntReg <= 2'd0;
        end else if (load && (loadSel == REG_IDX_W'(gi))) begin
          cntReg <= 2'(WB_LAT);
        end else if (cntReg != 2'd0) begin
          cntReg <= cntReg - 2'd1;
        end
      end

      assign cntAll[gi]   = cntReg;
      assign busyMask[gi] = (cntReg != 2'd0);
    end
  endgenerate

  assign rdCntA  = cntAll[rdSelA];
  assign rdCntB  = cntAll[rdSelB];
  assign allIdle = ~|busyMask;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencing: RAW stalls from the scoreboard, branch flushes,
// and a halt drain that waits for all older register writes to retire.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int WB_LAT    = 3,
  parameter int FLUSH_LEN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs_sel,
  input  logic                 id_rs_used,
  input  logic [REG_IDX_W-1:0] id_rt_sel,
  input  logic                 id_rt_used,
  input  logic                 id_reg_wrt,
  input  logic [REG_IDX_W-1:0] id_wrt_reg,
  input  logic                 id_halt,
  input  logic                 ex_do_branch,
  output logic                 stall,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 pc_hold,
  output logic                 halt_done,
  output logic [NUM_REGS-1:0]  busy_mask
);

  ctrlState_t stateReg, stateNext;
  logic [1:0] flushCntReg, flushCntNext;
  logic [1:0] cntRs, cntRt;
  logic       allIdle;
  logic       hazard;
  logic       issue;
  logic       runOrStall;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .WB_LAT   (WB_LAT)
  ) uScoreboard (
    .clk      (clk),
    .rst      (rst),
    .load     (issue & id_reg_wrt),
    .loadSel  (id_wrt_reg),
    .rdSelA   (id_rs_sel),
    .rdSelB   (id_rt_sel),
    .rdCntA   (cntRs),
    .rdCntB   (cntRt),
    .busyMask (busy_mask),
    .allIdle  (allIdle)
  );

  // Only counts >= 2 are unresolved; a count of 1 is served by the bypass.
  assign hazard = id_valid & ((id_rs_used & (cntRs >= 2'd2)) |
                              (id_rt_used & (cntRt >= 2'd2)));

  assign runOrStall = (stateReg == RUN) || (stateReg == STALL);
  assign issue      = runOrStall & id_valid & ~hazard & ~ex_do_branch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg    <= RUN;
      flushCntReg <= 2'd0;
    end else begin
      stateReg    <= stateNext;
      flushCntReg <= flushCntNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    flushCntNext = flushCntReg;
    stall        = 1'b0;
    pc_hold      = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    halt_done    = 1'b0;

    case (stateReg)
      RUN, STALL: begin
        stall   = hazard;
        pc_hold = hazard;
        if (hazard) begin
          stateNext = STALL;
        end else if (issue && id_halt) begin
          stateNext = DRAIN;
        end else begin
          stateNext = RUN;
        end
      end
      FLUSH: begin
        flush_if_id = 1'b1;
        if (flushCntReg == 2'd0) begin
          stateNext = RUN;
        end else begin
          flushCntNext = flushCntReg - 2'd1;
        end
      end
      DRAIN: begin
        stall   = 1'b1;
        pc_hold = 1'b1;
        if (allIdle) begin
          stateNext = HALTED;
        end
      end
      HALTED: begin
        stall     = 1'b1;
        pc_hold   = 1'b1;
        halt_done = 1'b1;
      end
      default: stateNext = RUN;
    endcase

    // A taken branch overrides everything except a completed halt; a halt
    // still draining was on the wrong path and is abandoned.
    if (ex_do_branch && (stateReg != HALTED)) begin
      flush_id_ex  = 1'b1;
      stateNext    = FLUSH;
      flushCntNext = 2'(FLUSH_LEN - 1);
    end
  end

endmodule
